frame_reduce_engine: RTL and testbench



---
 rtl/frame_reduce_engine_if.sv | 24 ++
 rtl/frame_reduce_engine.sv | 214 +++++++++++++++++++++
 tb/tb_frame_reduce_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/frame_reduce_engine_if.sv
// Source-ROM read port and framebuffer write port of the reduce engine.
interface frame_reduce_engine_if;
  logic [18:0] rom_addr;
  logic [7:0]  rom_data;
  logic [18:0] ram_wraddr;
  logic [7:0]  ram_data;
  logic        ram_wren;

  modport master (
    output rom_addr,
    input  rom_data,
    output ram_wraddr,
    output ram_data,
    output ram_wren
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  ram_wraddr,
    input  ram_data,
    input  ram_wren
  );
endinterface

// File: rtl/frame_reduce_engine.sv
// One-shot image engine: copy, decimate or block-average a grayscale ROM image
// into the centre of the framebuffer. Runs once after each reset release.
//
// state   | meaning
// --------+-----------------------------------------------------------
// START   | capture mode/factor, clear counters, present first address
// ADDR    | rom_addr holds the current sample address
// LATCH   | rom_data valid: store/accumulate, step to next sample or write
// WRITE   | ram_wren high with the output pixel and its address
// DONE    | all pixels written (or reserved mode); wait for reset
module frame_reduce_engine #(
  parameter int SRC_W = 160,
  parameter int SRC_H = 120,
  parameter int FB_W  = 640,
  parameter int FB_H  = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  fator4,
  output logic                  done,
  frame_reduce_engine_if.master bus
);

  localparam int AW = 19;
  localparam int XW = $clog2(SRC_W + 1);
  localparam int YW = $clog2(SRC_H + 1);

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] M_COPY = 2'b00;
  localparam logic [1:0] M_AVG  = 2'b10;
  localparam logic [1:0] M_RSVD = 2'b11;

  logic [2:0]    state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    shift_q, shift_d;    // log2 of the reduction factor
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;
  logic [1:0]    si_q, si_d;
  logic [1:0]    sj_q, sj_d;
  logic [11:0]   acc_q, acc_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [AW-1:0] ram_wraddr_q, ram_wraddr_d;
  logic [7:0]    ram_data_q, ram_data_d;
  logic          ram_wren_q, ram_wren_d;
  logic          done_q, done_d;

  int          ow_i, oh_i, x0_i, y0_i;
  logic [1:0]  f_m1;
  logic        is_avg;
  logic        last_sample;
  logic        last_col;
  logic        last_pix;
  logic [11:0] sum;
  logic [7:0]  avg_val;

  // Source address of sample (i, j) inside the block of output pixel (ox, oy).
  function automatic logic [AW-1:0] src_addr(input logic [XW-1:0] ox,
                                             input logic [YW-1:0] oy,
                                             input logic [1:0]    i,
                                             input logic [1:0]    j,
                                             input logic [1:0]    sh);
    int sx;
    int sy;
    sx = (int'(ox) << sh) + int'(i);
    sy = (int'(oy) << sh) + int'(j);
    return AW'(sy * SRC_W + sx);
  endfunction

  // Output geometry, block position and the averaged value for the current pixel.
  always_comb begin
    ow_i = SRC_W >> shift_q;
    oh_i = SRC_H >> shift_q;
    x0_i = (FB_W - ow_i) / 2;
    y0_i = (FB_H - oh_i) / 2;
    case (shift_q)
      2'd0:    f_m1 = 2'd0;
      2'd1:    f_m1 = 2'd1;
      default: f_m1 = 2'd3;
    endcase
    is_avg      = (mode_q == M_AVG);
    last_sample = !is_avg || ((si_q == f_m1) && (sj_q == f_m1));
    last_col    = (int'(ox_q) == ow_i - 1);
    last_pix    = last_col && (int'(oy_q) == oh_i - 1);
    sum         = acc_q + {4'd0, bus.rom_data};
    // Block of F*F samples: divide by 4 (F=2) or 16 (F=4), flooring.
    avg_val     = (shift_q == 2'd1) ? 8'(sum >> 2) : 8'(sum >> 4);
  end

  // Sequencer: walks output pixels in raster order and the samples of each block.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    shift_d      = shift_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    si_d         = si_q;
    sj_d         = sj_q;
    acc_d        = acc_q;
    rom_addr_d   = rom_addr_q;
    ram_wraddr_d = ram_wraddr_q;
    ram_data_d   = ram_data_q;
    ram_wren_d   = 1'b0;
    done_d       = done_q;

    case (state_q)
      S_START: begin
        mode_d     = mode;
        shift_d    = (mode == M_COPY) ? 2'd0 : (fator4 ? 2'd2 : 2'd1);
        ox_d       = '0;
        oy_d       = '0;
        si_d       = 2'd0;
        sj_d       = 2'd0;
        acc_d      = 12'd0;
        rom_addr_d = '0;
        if (mode == M_RSVD) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_ADDR;
        end
      end

      S_ADDR: state_d = S_LATCH;

      S_LATCH: begin
        if (!last_sample) begin
          acc_d = sum;
          if (si_q == f_m1) begin
            si_d = 2'd0;
            sj_d = sj_q + 2'd1;
          end else begin
            si_d = si_q + 2'd1;
          end
          rom_addr_d = src_addr(ox_q, oy_q, si_d, sj_d, shift_q);
          state_d    = S_ADDR;
        end else begin
          acc_d        = 12'd0;
          si_d         = 2'd0;
          sj_d         = 2'd0;
          ram_data_d   = is_avg ? avg_val : bus.rom_data;
          ram_wraddr_d = AW'((y0_i + int'(oy_q)) * FB_W + x0_i + int'(ox_q));
          ram_wren_d   = 1'b1;
          state_d      = S_WRITE;
        end
      end

      S_WRITE: begin
        if (last_pix) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          if (last_col) begin
            ox_d = '0;
            oy_d = oy_q + YW'(1);
          end else begin
            ox_d = ox_q + XW'(1);
          end
          rom_addr_d = src_addr(ox_d, oy_d, 2'd0, 2'd0, shift_q);
          state_d    = S_ADDR;
        end
      end

      S_DONE: state_d = S_DONE;

      default: state_d = S_START;
    endcase
  end

  // State and registered outputs; reset aborts and clears everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_START;
      mode_q       <= 2'b00;
      shift_q      <= 2'd0;
      ox_q         <= '0;
      oy_q         <= '0;
      si_q         <= 2'd0;
      sj_q         <= 2'd0;
      acc_q        <= 12'd0;
      rom_addr_q   <= '0;
      ram_wraddr_q <= '0;
      ram_data_q   <= 8'd0;
      ram_wren_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      shift_q      <= shift_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      si_q         <= si_d;
      sj_q         <= sj_d;
      acc_q        <= acc_d;
      rom_addr_q   <= rom_addr_d;
      ram_wraddr_q <= ram_wraddr_d;
      ram_data_q   <= ram_data_d;
      ram_wren_q   <= ram_wren_d;
      done_q       <= done_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.ram_wraddr = ram_wraddr_q;
  assign bus.ram_data   = ram_data_q;
  assign bus.ram_wren   = ram_wren_q;
  assign done           = done_q;

endmodule

// File: tb/tb_frame_reduce_engine.sv
// Bench for frame_reduce_engine: table of whole-image runs plus random-ROM runs,
// each write compared against a block-mean model of the source image.
module tb_frame_reduce_engine;
  localparam int SRC_W = 160;
  localparam int SRC_H = 120;
  localparam int FB_W  = 640;
  localparam int FB_H  = 480;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       fator4 = 1'b0;
  logic       done;

  frame_reduce_engine_if bus ();

  frame_reduce_engine #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .FB_W(FB_W), .FB_H(FB_H)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .fator4(fator4), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  int          rom_kind = 0;
  int unsigned rm_mul = 0;
  int unsigned rm_add = 0;

  function automatic logic [7:0] rom_fn(int a);
    int unsigned v;
    if (rom_kind == 0) return 8'(a);
    v = (int'(a) * rm_mul + rm_add) >> 3;
    return 8'(v);
  endfunction

  // Synchronous ROM: data follows the address by one clock.
  always @(posedge clk) bus.rom_data <= rom_fn(int'(bus.rom_addr));

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Floor of the mean of the source block feeding output pixel (ox, oy).
  function automatic int exp_pix(int md, int f, int ox, int oy);
    int k;
    int s;
    k = (md == 2) ? f : 1;
    s = 0;
    for (int j = 0; j < k; j++)
      for (int i = 0; i < k; i++)
        s += int'(rom_fn((oy * f + j) * SRC_W + ox * f + i));
    return s / (k * k);
  endfunction

  typedef struct {
    string nm;
    int    md;
    int    f4;
    int    max_wr;     // 0: run to completion
    int    exp_fa;     // -1 fields are not checked
    int    exp_fd;
    int    exp_wr;
    int    exp_done;   // posedge count after release at which done is first seen
    int    exp_la;
    int    exp_ld;
    bit    toggle;
  } vec_t;

  task automatic run_case(input vec_t v);
    int f, ow, oh, x0, y0, n, per, target, budget;
    int wr, errs, done_p, fa, fd, la, ld, ox, oy, ea, ed, extra, done_lo;
    bit fin;
    reset  = 1'b0;
    mode   = v.md[1:0];
    fator4 = v.f4[0];
    repeat (2) @(posedge clk);
    #1;
    check({v.nm, "_reset_outs"},
          int'(bus.rom_addr) + int'(bus.ram_wraddr) + int'(bus.ram_data) +
          int'(bus.ram_wren) + int'(done), 0);
    @(negedge clk);
    reset = 1'b1;

    f      = (v.md == 0) ? 1 : (v.f4 != 0 ? 4 : 2);
    ow     = SRC_W / f;
    oh     = SRC_H / f;
    x0     = (FB_W - ow) / 2;
    y0     = (FB_H - oh) / 2;
    n      = (v.md == 2) ? f * f : 1;
    per    = 2 * n + 1;
    target = (v.md == 3) ? 0 : (v.max_wr > 0 ? v.max_wr : ow * oh);
    budget = target * per + 20;
    wr = 0; errs = 0; done_p = -1; fa = -1; fd = -1; la = -1; ld = -1; fin = 0;

    for (int p = 1; p <= budget && !fin; p++) begin
      @(posedge clk);
      #1;
      if (v.toggle) begin
        mode   = 2'($urandom_range(0, 3));
        fator4 = 1'($urandom);
      end
      if (bus.ram_wren) begin
        ox = wr % ow;
        oy = wr / ow;
        ea = (y0 + oy) * FB_W + x0 + ox;
        ed = exp_pix(v.md, f, ox, oy);
        if (int'(bus.ram_wraddr) != ea || int'(bus.ram_data) != ed ||
            p != (wr + 1) * per || done) begin
          if (errs == 0)
            $display("%s: write %0d deviates at cycle %0d: addr %0d/%0d data %0d/%0d",
                     v.nm, wr, p, bus.ram_wraddr, ea, bus.ram_data, ed);
          errs++;
        end
        if (wr == 0) begin fa = int'(bus.ram_wraddr); fd = int'(bus.ram_data); end
        la = int'(bus.ram_wraddr);
        ld = int'(bus.ram_data);
        wr++;
      end
      if (done && done_p < 0) done_p = p;
      if (v.max_wr > 0 ? (wr >= v.max_wr) : (done_p >= 0)) fin = 1;
    end

    check({v.nm, "_completed"}, int'(fin), 1);
    check({v.nm, "_stream_errs"}, errs, 0);
    if (v.exp_fa >= 0) begin
      check({v.nm, "_first_addr"}, fa, v.exp_fa);
      check({v.nm, "_first_data"}, fd, v.exp_fd);
    end
    if (v.exp_wr >= 0) check({v.nm, "_writes"}, wr, v.exp_wr);
    if (v.exp_la >= 0) begin
      check({v.nm, "_last_addr"}, la, v.exp_la);
      check({v.nm, "_last_data"}, ld, v.exp_ld);
    end
    if (v.exp_done >= 0) begin
      check({v.nm, "_done_cycle"}, done_p, v.exp_done);
      extra = 0;
      done_lo = 0;
      repeat (6) begin
        @(posedge clk);
        #1;
        extra += int'(bus.ram_wren);
        done_lo += int'(!done);
      end
      check({v.nm, "_quiet_after_done"}, extra + done_lo, 0);
    end
  endtask

  vec_t vecs[$];
  vec_t rv;

  initial begin
    vecs.push_back('{"copy",   0, 0, 0,  115440, 0,   19200, 57601, 191759, 255, 1'b0});
    vecs.push_back('{"dec2",   1, 0, 0,  134680, 0,   4800,  14401, 172519, 94,  1'b1});
    vecs.push_back('{"dec4",   1, 1, 0,  144300, 0,   1200,  3601,  162899, 28,  1'b0});
    vecs.push_back('{"avg2",   2, 0, 40, 134680, 80,  40,    -1,    -1,     -1,  1'b0});
    vecs.push_back('{"avg4",   2, 1, 20, 144300, 113, 20,    -1,    -1,     -1,  1'b0});
    vecs.push_back('{"rsvd",   3, 0, 0,  -1,     -1,  0,     1,     -1,     -1,  1'b0});
    vecs.push_back('{"rsvd_f4",3, 1, 0,  -1,     -1,  0,     1,     -1,     -1,  1'b1});

    rom_kind = 0;
    foreach (vecs[k]) run_case(vecs[k]);

    // Abort a copy mid-run and restart it.
    run_case('{"copy_pre", 0, 0, 10, 115440, 0, 10, -1, -1, -1, 1'b0});
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("abort_outs_async",
          int'(bus.rom_addr) + int'(bus.ram_wraddr) + int'(bus.ram_data) +
          int'(bus.ram_wren) + int'(done), 0);
    @(posedge clk);
    #1;
    check("abort_outs_held",
          int'(bus.rom_addr) + int'(bus.ram_wraddr) + int'(bus.ram_data) +
          int'(bus.ram_wren) + int'(done), 0);
    run_case('{"copy_restart", 0, 0, 8, 115440, 0, 8, -1, -1, -1, 1'b0});

    // Random ROM contents, modes and factors.
    rom_kind = 1;
    for (int r = 0; r < 4; r++) begin
      rm_mul = $urandom;
      rm_add = $urandom;
      rv = '{"rand", int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 20,
             -1, -1, 20, -1, -1, -1, 1'($urandom)};
      run_case(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
